// File: rtl/flow_key_extractor_pkg.sv
// Shared constants, FSM state type and the packed flow-key record used by the
// extractor and by the classifier lookup side.
package flow_key_extractor_pkg;

  localparam logic [7:0]  IOQ_CTRL_DEF   = 8'hFF;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  PROTO_TCP      = 8'd6;
  localparam logic [7:0]  PROTO_UDP      = 8'd17;
  localparam int          KEY_W          = 120;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  // MSB-first layout; total width equals KEY_W
  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [7:0]  proto;
    logic [15:0] ip_len;
  } flow_key_t;

endpackage

// File: rtl/flow_key_fifo.sv
// Synchronous key FIFO with occupancy count; head is shown from registered
// storage and reads as zero while empty.
module flow_key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 120
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign do_pop  = pop & valid;
  assign do_push = push & ((count != FULL_CNT) | do_pop);
  assign dout    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/flow_key_extractor.sv
// 1-cycle pass-through stage that parses Ethernet/IPv4/L4 headers and queues
// one flow key per IPv4 packet on a valid/ready side channel.
//
// state  | meaning
// IDLE   | between packets, waiting for an IOQ module header
// HDR    | inside module headers of a packet
// DATA   | inside packet data words, idx counts words (saturates at 7)
module flow_key_extractor
  import flow_key_extractor_pkg::*;
#(
  parameter int         KEY_FIFO_DEPTH = 4,
  parameter logic [7:0] IOQ_CTRL       = IOQ_CTRL_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] in_data,
  input  logic [7:0]  in_ctrl,
  input  logic        in_wr,
  output logic        in_rdy,
  output logic [63:0] out_data,
  output logic [7:0]  out_ctrl,
  output logic        out_wr,
  input  logic        out_rdy,
  output logic        key_valid,
  input  logic        key_rdy,
  output logic [31:0] key_src_ip,
  output logic [31:0] key_dst_ip,
  output logic [15:0] key_src_port,
  output logic [15:0] key_dst_port,
  output logic [7:0]  key_proto,
  output logic [15:0] key_ip_len,
  output logic [31:0] stat_pkts,
  output logic [31:0] stat_keys,
  output logic [31:0] stat_nokey
);

  localparam int CW = $clog2(KEY_FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] RDY_MAX = CW'(KEY_FIFO_DEPTH - 2);

  state_t      state, state_next;
  logic [2:0]  idx, idx_next;
  logic        accept, sop, pkt_end, cap_en;
  logic        push_pend, key_push, got_key, is_ipv4, l4_ok;
  logic [15:0] ethertype, ip_len, sport, dport;
  logic [7:0]  ver_ihl, proto;
  logic [31:0] src_ip, dst_ip;
  logic [CW-1:0] fifo_count;
  flow_key_t   key_din, key_head;

  // Leaving room for one entry guarantees the deferred push always fits
  assign in_rdy = out_rdy & (fifo_count <= RDY_MAX);
  assign accept = in_wr & in_rdy;
  assign sop    = accept & (in_ctrl == IOQ_CTRL);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      out_ctrl <= '0;
      out_wr   <= 1'b0;
    end else begin
      out_data <= in_data;
      out_ctrl <= in_ctrl;
      out_wr   <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    pkt_end    = 1'b0;
    cap_en     = 1'b0;
    if (accept) begin
      case (state)
        S_IDLE: if (in_ctrl == IOQ_CTRL) state_next = S_HDR;
        S_HDR: begin
          if (in_ctrl == IOQ_CTRL) begin
            pkt_end = 1'b1;
          end else if (in_ctrl == 8'h00) begin
            state_next = S_DATA;
            idx_next   = 3'd1;
          end
        end
        S_DATA: begin
          if (in_ctrl == 8'h00) begin
            cap_en = 1'b1;
            if (idx != 3'd7) idx_next = idx + 3'd1;
          end else begin
            pkt_end    = 1'b1;
            state_next = (in_ctrl == IOQ_CTRL) ? S_HDR : S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ethertype <= '0;
      ver_ihl   <= '0;
      ip_len    <= '0;
      proto     <= '0;
      src_ip    <= '0;
      dst_ip    <= '0;
      sport     <= '0;
      dport     <= '0;
      push_pend <= 1'b0;
    end else begin
      push_pend <= cap_en & (idx == 3'd4);
      if (cap_en) begin
        case (idx)
          3'd1: begin
            ethertype <= in_data[31:16];
            ver_ihl   <= in_data[15:8];
          end
          3'd2: begin
            ip_len <= in_data[63:48];
            proto  <= in_data[7:0];
          end
          3'd3: begin
            src_ip        <= in_data[47:16];
            dst_ip[31:16] <= in_data[15:0];
          end
          3'd4: begin
            dst_ip[15:0] <= in_data[63:48];
            sport        <= in_data[47:32];
            dport        <= in_data[31:16];
          end
          default: ;
        endcase
      end
    end
  end

  assign is_ipv4  = (ethertype == ETHERTYPE_IPV4) & (ver_ihl[7:4] == 4'd4);
  assign l4_ok    = (ver_ihl == 8'h45) & ((proto == PROTO_TCP) | (proto == PROTO_UDP));
  assign key_push = push_pend & is_ipv4;

  assign key_din.src_ip   = src_ip;
  assign key_din.dst_ip   = dst_ip;
  assign key_din.src_port = l4_ok ? sport : 16'h0;
  assign key_din.dst_port = l4_ok ? dport : 16'h0;
  assign key_din.proto    = proto;
  assign key_din.ip_len   = ip_len;

  // A push landing on the same cycle as the next SOP belongs to the old packet
  always_ff @(posedge clk) begin
    if (reset) begin
      got_key    <= 1'b0;
      stat_pkts  <= '0;
      stat_keys  <= '0;
      stat_nokey <= '0;
    end else begin
      if (sop)           got_key <= 1'b0;
      else if (key_push) got_key <= 1'b1;
      if (sop)      stat_pkts <= stat_pkts + 32'd1;
      if (key_push) stat_keys <= stat_keys + 32'd1;
      if (pkt_end & ~(got_key | key_push)) stat_nokey <= stat_nokey + 32'd1;
    end
  end

  flow_key_fifo #(
    .DEPTH (KEY_FIFO_DEPTH),
    .WIDTH (KEY_W)
  ) u_key_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (key_push),
    .din   (key_din),
    .pop   (key_rdy),
    .dout  (key_head),
    .valid (key_valid),
    .count (fifo_count)
  );

  assign key_src_ip   = key_head.src_ip;
  assign key_dst_ip   = key_head.dst_ip;
  assign key_src_port = key_head.src_port;
  assign key_dst_port = key_head.dst_port;
  assign key_proto    = key_head.proto;
  assign key_ip_len   = key_head.ip_len;

endmodule

// File: tb/tb_flow_key_extractor.sv
// Directed bench for flow_key_extractor: pass-through stream, key side channel,
// statistics, back-pressure and mid-packet reset.
module tb_flow_key_extractor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;
  logic        key_valid;
  logic        key_rdy = 1'b1;
  logic [31:0] key_src_ip, key_dst_ip;
  logic [15:0] key_src_port, key_dst_port, key_ip_len;
  logic [7:0]  key_proto;
  logic [31:0] stat_pkts, stat_keys, stat_nokey;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit toggle_mode = 1'b0;

  logic        exp_wr;
  logic [63:0] exp_data;
  logic [7:0]  exp_ctrl;
  logic [119:0] exp_keys [$];
  logic [63:0] pkts [3][5];

  localparam logic [119:0] KEY_TCP = {32'hc06c7594, 32'h93e5b00e, 16'hce87, 16'h0016, 8'h06, 16'h0058};
  localparam logic [119:0] KEY_UDP = {32'h5bbd5e04, 32'hc06c7594, 16'h007b, 16'h007b, 8'h11, 16'h004c};

  flow_key_extractor #(.KEY_FIFO_DEPTH(4), .IOQ_CTRL(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .key_valid(key_valid), .key_rdy(key_rdy),
    .key_src_ip(key_src_ip), .key_dst_ip(key_dst_ip),
    .key_src_port(key_src_port), .key_dst_port(key_dst_port),
    .key_proto(key_proto), .key_ip_len(key_ip_len),
    .stat_pkts(stat_pkts), .stat_keys(stat_keys), .stat_nokey(stat_nokey)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) exp_wr <= 1'b0;
    else begin
      exp_wr   <= in_wr;
      exp_data <= in_data;
      exp_ctrl <= in_ctrl;
    end
  end

  // Output stream must equal the accepted input stream one cycle later
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      chk("out_wr", 64'(out_wr), 64'(exp_wr));
      if (exp_wr) begin
        chk("out_data", out_data, exp_data);
        chk("out_ctrl", 64'(out_ctrl), 64'(exp_ctrl));
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (mon_en && key_valid && key_rdy) begin
      if (exp_keys.size() == 0) chk("key_unexpected", 64'd1, 64'd0);
      else begin
        logic [119:0] k;
        k = exp_keys.pop_front();
        chk("key_src_ip",   64'(key_src_ip),   64'(k[119:88]));
        chk("key_dst_ip",   64'(key_dst_ip),   64'(k[87:56]));
        chk("key_src_port", 64'(key_src_port), 64'(k[55:40]));
        chk("key_dst_port", 64'(key_dst_port), 64'(k[39:24]));
        chk("key_proto",    64'(key_proto),    64'(k[23:16]));
        chk("key_ip_len",   64'(key_ip_len),   64'(k[15:0]));
      end
    end
  end

  task automatic send_word(input logic [63:0] d, input logic [7:0] c);
    int waits = 0;
    bit done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (toggle_mode) out_rdy = ((cyc % 5) != 4);
      #1;
      if (toggle_mode) chk("in_rdy_track", 64'(in_rdy), 64'(out_rdy));
      in_data = d;
      in_ctrl = c;
      if (in_rdy) begin
        in_wr = 1'b1;
        done = 1'b1;
      end else begin
        in_wr = 1'b0;
        waits++;
        if (waits > 200) begin
          chk("send_timeout", 64'd0, 64'd1);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      in_wr = 1'b0;
    end
  endtask

  task automatic send_pkt(input int kind, input int nwords, input logic [7:0] eop_ctrl);
    send_word(64'h0, 8'hFF);
    for (int i = 0; i < nwords; i++) send_word(pkts[kind][i], 8'h00);
    if (eop_ctrl != 8'h00) send_word(64'h0123456789abcdef, eop_ctrl);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    in_wr = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain_keys(input string tag);
    int n = 0;
    while (key_valid && n < 100) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk(tag, 64'(key_valid), 64'd0);
  endtask

  task automatic chk_stats(input string tag, input int p, input int k, input int nk);
    chk({tag, "_pkts"},  64'(stat_pkts),  64'(p));
    chk({tag, "_keys"},  64'(stat_keys),  64'(k));
    chk({tag, "_nokey"}, 64'(stat_nokey), 64'(nk));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pkts[0] = '{64'h0023ebf960000017, 64'ha44081e408004510, 64'h0058070e40004006,
                64'hb98dc06c759493e5, 64'hb00ece870016cec4};
    pkts[1] = '{64'h0017a44081e40023, 64'hebf9600008004500, 64'h004c000040002c11,
                64'h5edf5bbd5e04c06c, 64'h7594007b007b0038};
    pkts[2] = '{64'h0023ebf960000017, 64'ha44081e408064510, 64'h0058070e40004006,
                64'hb98dc06c759493e5, 64'hb00ece870016cec4};

    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    #2;
    chk("rst_out_wr", 64'(out_wr), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_key_valid", 64'(key_valid), 64'd0);
    chk("rst_key_src", 64'(key_src_ip), 64'd0);
    chk("rst_key_len", 64'(key_ip_len), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk_stats("rst", 0, 0, 0);
    mon_en = 1'b1;

    // TCP then UDP
    exp_keys.push_back(KEY_TCP);
    send_pkt(0, 5, 8'h01);
    idle(4);
    drain_keys("s1_drain");
    chk_stats("s1", 1, 1, 0);
    exp_keys.push_back(KEY_UDP);
    send_pkt(1, 5, 8'h01);
    idle(4);
    drain_keys("s2_drain");
    chk_stats("s2", 2, 2, 0);

    // ARP: no key
    do_reset();
    send_pkt(2, 5, 8'h01);
    idle(4);
    chk("s3_key_valid", 64'(key_valid), 64'd0);
    chk_stats("s3", 1, 0, 1);

    // Three back-to-back TCP packets with the consumer stalled
    do_reset();
    @(negedge clk);
    #1;
    key_rdy = 1'b0;
    for (int p = 0; p < 3; p++) begin
      exp_keys.push_back(KEY_TCP);
      send_pkt(0, 5, 8'h01);
    end
    idle(3);
    #2;
    chk("s4_in_rdy_low", 64'(in_rdy), 64'd0);
    chk("s4_key_valid", 64'(key_valid), 64'd1);
    chk_stats("s4", 3, 3, 0);
    @(negedge clk);
    #1;
    key_rdy = 1'b1;
    drain_keys("s4_drain");
    chk("s4_in_rdy_back", 64'(in_rdy), 64'd1);

    // out_rdy periodically low during a TCP packet
    exp_keys.push_back(KEY_TCP);
    toggle_mode = 1'b1;
    send_pkt(0, 5, 8'h01);
    toggle_mode = 1'b0;
    idle(1);
    out_rdy = 1'b1;
    idle(3);
    drain_keys("s5_drain");
    chk_stats("s5", 4, 4, 0);

    // Reset while at idx2 of a packet, then a clean TCP packet
    send_word(64'h0, 8'hFF);
    for (int i = 0; i < 3; i++) send_word(pkts[0][i], 8'h00);
    do_reset();
    #2;
    chk("s6_rst_key_valid", 64'(key_valid), 64'd0);
    chk_stats("s6_rst", 0, 0, 0);
    exp_keys.push_back(KEY_TCP);
    send_pkt(0, 5, 8'h01);
    idle(4);
    drain_keys("s6_drain");
    chk_stats("s6", 1, 1, 0);

    idle(2);
    chk("keys_outstanding", 64'(exp_keys.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
